// File: rtl/sdc_req_queue.sv
// sdc_req_queue
// Host-side request queue in front of an SDRAM controller host port.
// Host commands are buffered in a 4-entry command FIFO and write data in an
// 8-entry write-data FIFO. A small FSM issues one request at a time to the
// controller. It streams write data out on sdr_wr_next and returns read data
// with one cycle of latency.
//
// Ports
//   mclk, s_resetn          clock, asynchronous active-low reset
//   cmd_*                   host command push {adr, len (beats-1), wr_n}
//   wd_*                    host write-data push {data, byte enables (active low)}
//   rd_valid, rd_data       read data returned to the host
//   sdr_req*                request to the controller, held until sdr_req_ack
//   sdr_wr_next             controller consumes the write-FIFO head word
//   sdr_wr_data/en_n        current write-FIFO head word
//   sdr_rd_valid/data       controller read beats
//   sdr_init_done           controller ready; gates new requests only
//   busy, cmd_cnt, wr_uflow status: FSM active, command occupancy, sticky underflow

`ifndef U_ADDR_MSB
`define U_ADDR_MSB 23
`endif
`ifndef U_DATA_MSB
`define U_DATA_MSB 31
`endif

module sdc_req_queue (
  input  logic                 mclk,
  input  logic                 s_resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [`U_ADDR_MSB:0] cmd_adr,
  input  logic [1:0]           cmd_len,
  input  logic                 cmd_wr_n,
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [`U_DATA_MSB:0] wd_data,
  input  logic [3:0]           wd_en_n,
  output logic                 rd_valid,
  output logic [`U_DATA_MSB:0] rd_data,
  output logic                 sdr_req,
  output logic [`U_ADDR_MSB:0] sdr_req_adr,
  output logic [1:0]           sdr_req_len,
  output logic                 sdr_req_wr_n,
  input  logic                 sdr_req_ack,
  input  logic                 sdr_wr_next,
  input  logic                 sdr_rd_valid,
  input  logic                 sdr_init_done,
  input  logic [`U_DATA_MSB:0] sdr_rd_data,
  output logic [`U_DATA_MSB:0] sdr_wr_data,
  output logic [3:0]           sdr_wr_en_n,
  output logic                 busy,
  output logic [2:0]           cmd_cnt,
  output logic                 wr_uflow
);

  localparam int AW = `U_ADDR_MSB + 1;
  localparam int DW = `U_DATA_MSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WXFER = 2'd2,
    RXFER = 2'd3
  } state_t;

  state_t state_r, state_nx_s;
  logic   go_s;

  // command FIFO
  logic [AW+2:0] cmd_mem_r [0:3];
  logic [1:0]    cmd_wr_ptr_r, cmd_rd_ptr_r;
  logic [2:0]    cmd_cnt_r, cmd_cnt_nx_s;
  logic          cmd_ready_r;
  logic          cmd_push_s, cmd_pop_s;
  logic [AW-1:0] head_adr_s;
  logic [1:0]    head_len_s;
  logic          head_wr_n_s;

  // write-data FIFO
  logic [DW+3:0] wd_mem_r [0:7];
  logic [2:0]    wd_wr_ptr_r, wd_rd_ptr_r, wd_rd_ptr_nx_s;
  logic [3:0]    wd_cnt_r, wd_cnt_nx_s;
  logic          wd_ready_r;
  logic          wd_push_s, wd_pop_s;
  logic [DW+3:0] wd_head_nx_s;
  logic [DW-1:0] sdr_wr_data_r;
  logic [3:0]    sdr_wr_en_n_r;

  // request / transfer registers
  logic          sdr_req_r;
  logic [AW-1:0] sdr_req_adr_r;
  logic [1:0]    sdr_req_len_r;
  logic          sdr_req_wr_n_r;
  logic [1:0]    beat_cnt_r;
  logic          rd_valid_r;
  logic [DW-1:0] rd_data_r;
  logic          busy_r;
  logic          wr_uflow_r;

  assign cmd_push_s = cmd_valid && cmd_ready_r;
  assign cmd_pop_s  = go_s;
  assign {head_adr_s, head_len_s, head_wr_n_s} = cmd_mem_r[cmd_rd_ptr_r];

  assign wd_push_s  = wd_valid && wd_ready_r;
  assign wd_pop_s   = (state_r == WXFER) && sdr_wr_next && (wd_cnt_r != 4'd0);

  // Next-state decode; go_s marks the IDLE->REQ step that pops the command head.
  always_comb begin
    state_nx_s = state_r;
    go_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // a write only issues once its whole burst is already buffered
        if (sdr_init_done && (cmd_cnt_r != 3'd0) &&
            (head_wr_n_s || (wd_cnt_r >= ({2'b00, head_len_s} + 4'd1)))) begin
          go_s       = 1'b1;
          state_nx_s = REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (sdr_req_ack) begin
          if (sdr_req_wr_n_r) begin
            state_nx_s = RXFER;
          end else begin
            state_nx_s = WXFER;
          end
        end else begin
          state_nx_s = REQ;
        end
      end
      WXFER: begin
        if (sdr_wr_next && (beat_cnt_r == 2'd0)) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WXFER;
        end
      end
      RXFER: begin
        if (sdr_rd_valid && (beat_cnt_r == 2'd0)) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RXFER;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state register and busy flag.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
    end
  end

  // Command FIFO occupancy after this cycle's push/pop.
  always_comb begin
    cmd_cnt_nx_s = cmd_cnt_r;
    case ({cmd_push_s, cmd_pop_s})
      2'b10:   cmd_cnt_nx_s = cmd_cnt_r + 3'd1;
      2'b01:   cmd_cnt_nx_s = cmd_cnt_r - 3'd1;
      default: cmd_cnt_nx_s = cmd_cnt_r;
    endcase
  end

  // Command FIFO pointers, count and registered ready.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      cmd_wr_ptr_r <= 2'd0;
      cmd_rd_ptr_r <= 2'd0;
      cmd_cnt_r    <= 3'd0;
      cmd_ready_r  <= 1'b1;
    end else begin
      if (cmd_push_s) begin
        cmd_wr_ptr_r <= cmd_wr_ptr_r + 2'd1;
      end
      if (cmd_pop_s) begin
        cmd_rd_ptr_r <= cmd_rd_ptr_r + 2'd1;
      end
      cmd_cnt_r   <= cmd_cnt_nx_s;
      cmd_ready_r <= (cmd_cnt_nx_s < 3'd4);
    end
  end

  // Command FIFO storage; contents are only observed while occupied.
  always_ff @(posedge mclk) begin
    if (cmd_push_s) begin
      cmd_mem_r[cmd_wr_ptr_r] <= {cmd_adr, cmd_len, cmd_wr_n};
    end
  end

  // Write FIFO next occupancy, next read pointer and next head word.
  always_comb begin
    wd_cnt_nx_s    = wd_cnt_r;
    wd_rd_ptr_nx_s = wd_rd_ptr_r;
    wd_head_nx_s   = {{DW{1'b0}}, 4'hF};
    case ({wd_push_s, wd_pop_s})
      2'b10:   wd_cnt_nx_s = wd_cnt_r + 4'd1;
      2'b01:   wd_cnt_nx_s = wd_cnt_r - 4'd1;
      default: wd_cnt_nx_s = wd_cnt_r;
    endcase
    if (wd_pop_s) begin
      wd_rd_ptr_nx_s = wd_rd_ptr_r + 3'd1;
    end else begin
      wd_rd_ptr_nx_s = wd_rd_ptr_r;
    end
    // the head register is loaded one cycle ahead, so a word written this
    // cycle into the next head slot must bypass the storage array
    if (wd_cnt_nx_s == 4'd0) begin
      wd_head_nx_s = {{DW{1'b0}}, 4'hF};
    end else if (wd_push_s && (wd_wr_ptr_r == wd_rd_ptr_nx_s)) begin
      wd_head_nx_s = {wd_data, wd_en_n};
    end else begin
      wd_head_nx_s = wd_mem_r[wd_rd_ptr_nx_s];
    end
  end

  // Write FIFO pointers, count, ready, registered head and underflow flag.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      wd_wr_ptr_r   <= 3'd0;
      wd_rd_ptr_r   <= 3'd0;
      wd_cnt_r      <= 4'd0;
      wd_ready_r    <= 1'b1;
      sdr_wr_data_r <= {DW{1'b0}};
      sdr_wr_en_n_r <= 4'hF;
      wr_uflow_r    <= 1'b0;
    end else begin
      if (wd_push_s) begin
        wd_wr_ptr_r <= wd_wr_ptr_r + 3'd1;
      end
      wd_rd_ptr_r                    <= wd_rd_ptr_nx_s;
      wd_cnt_r                       <= wd_cnt_nx_s;
      wd_ready_r                     <= (wd_cnt_nx_s < 4'd8);
      {sdr_wr_data_r, sdr_wr_en_n_r} <= wd_head_nx_s;
      // any consume strobe against an empty FIFO is an error, whatever the state
      if (sdr_wr_next && (wd_cnt_r == 4'd0)) begin
        wr_uflow_r <= 1'b1;
      end
    end
  end

  // Write FIFO storage.
  always_ff @(posedge mclk) begin
    if (wd_push_s) begin
      wd_mem_r[wd_wr_ptr_r] <= {wd_data, wd_en_n};
    end
  end

  // Request registers: loaded from the command head, held until acknowledged.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      sdr_req_r      <= 1'b0;
      sdr_req_adr_r  <= {AW{1'b0}};
      sdr_req_len_r  <= 2'd0;
      sdr_req_wr_n_r <= 1'b1;
    end else if (go_s) begin
      sdr_req_r      <= 1'b1;
      sdr_req_adr_r  <= head_adr_s;
      sdr_req_len_r  <= head_len_s;
      sdr_req_wr_n_r <= head_wr_n_s;
    end else if ((state_r == REQ) && sdr_req_ack) begin
      sdr_req_r <= 1'b0;
    end
  end

  // Remaining-beat counter for the active burst.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      beat_cnt_r <= 2'd0;
    end else if ((state_r == REQ) && sdr_req_ack) begin
      beat_cnt_r <= sdr_req_len_r;
    end else if ((((state_r == WXFER) && sdr_wr_next) ||
                  ((state_r == RXFER) && sdr_rd_valid)) && (beat_cnt_r != 2'd0)) begin
      beat_cnt_r <= beat_cnt_r - 2'd1;
    end
  end

  // Read return path with one cycle of latency; beats outside RXFER are dropped.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DW{1'b0}};
    end else begin
      rd_valid_r <= (state_r == RXFER) && sdr_rd_valid;
      if ((state_r == RXFER) && sdr_rd_valid) begin
        rd_data_r <= sdr_rd_data;
      end
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign wd_ready     = wd_ready_r;
  assign cmd_cnt      = cmd_cnt_r;
  assign busy         = busy_r;
  assign wr_uflow     = wr_uflow_r;
  assign sdr_req      = sdr_req_r;
  assign sdr_req_adr  = sdr_req_adr_r;
  assign sdr_req_len  = sdr_req_len_r;
  assign sdr_req_wr_n = sdr_req_wr_n_r;
  assign sdr_wr_data  = sdr_wr_data_r;
  assign sdr_wr_en_n  = sdr_wr_en_n_r;
  assign rd_valid     = rd_valid_r;
  assign rd_data      = rd_data_r;

endmodule

// File: doc/sdc_req_queue.md
SDC_REQ_QUEUE -- requirements
Module: sdc_req_queue

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: mclk  in  1  clock; all state on rising edge.
REQ-003 Port: s_resetn  in  1  asynchronous active-low reset.
REQ-004 Port: cmd_valid / cmd_ready  in/out  1  host command handshake; transfer when both are high.
REQ-005 Port: cmd_adr  in  `U_ADDR_MSB+1  word address; cmd_len  in  2  burst length minus 1 (1..4 words); cmd_wr_n  in  1  0=write, 1=read.
REQ-006 Port: wd_valid / wd_ready  in/out  1  write-data push handshake; wd_data  in  `U_DATA_MSB+1; wd_en_n  in  4  byte enables, active low.
REQ-007 Port: rd_valid  out  1 and rd_data  out  `U_DATA_MSB+1  read data returned to host.
REQ-008 Port: sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n  out  1/`U_ADDR_MSB+1/2/1  request to the SDRAM controller host port.
REQ-009 Port: sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done  in  1  controller responses; sdr_rd_data  in  `U_DATA_MSB+1.
REQ-010 Port: sdr_wr_data  out  `U_DATA_MSB+1 and sdr_wr_en_n  out  4  carry the head word of the write-data FIFO.
REQ-011 Port: busy  out  1  FSM not in IDLE; cmd_cnt  out  3  command FIFO occupancy (0..4); wr_uflow  out  1  sticky underflow error flag.

Function
REQ-012 Command FIFO: 4 entries {adr, len, wr_n}; cmd_ready = (cmd_cnt < 4).
REQ-013 Write-data FIFO: 8 entries {data, en_n}; wd_ready = (occupancy < 8); pointers are 3 bits and wrap 7->0.
REQ-014 FSM states: IDLE, REQ, WXFER, RXFER.
REQ-015 IDLE->REQ when sdr_init_done=1, command FIFO is non-empty, and, for a write head entry, write-FIFO occupancy >= len+1; otherwise the FSM stays in IDLE.
REQ-016 On entry to REQ, the head command is popped into the sdr_req_* registers and sdr_req=1 in the next cycle.
REQ-017 In REQ, sdr_req and its fields are held stable until sdr_req_ack=1 is sampled; in that cycle sdr_req falls, beat_cnt loads len, and the FSM moves to WXFER (write) or RXFER (read).
REQ-018 In WXFER, each sdr_wr_next=1 pops one write-FIFO word and sdr_wr_data/sdr_wr_en_n present the new head in the next cycle. On the beat where beat_cnt=0, the FSM moves to IDLE; otherwise beat_cnt decrements.
REQ-019 In RXFER, each sdr_rd_valid=1 registers sdr_rd_data into rd_data with rd_valid=1 one cycle later (latency 1). On the beat where beat_cnt=0, the FSM moves to IDLE.
REQ-020 sdr_wr_next outside WXFER SHALL be ignored; sdr_rd_valid outside RXFER SHALL be ignored, and rd_valid stays 0.
REQ-021 sdr_wr_next while the write FIFO is empty: no pop, pointers unchanged, and wr_uflow set to 1 until reset.
REQ-022 Simultaneous push and pop on either FIFO: occupancy unchanged and both operations take effect. A push when full is dropped, since the ready signal is low.
REQ-023 Minimum issue rate: back-to-back commands SHALL spend at least one cycle in IDLE between transfers.
REQ-024 sdr_init_done falling mid-transfer SHALL NOT abort the current transfer; it only blocks the next IDLE->REQ.

Reset
REQ-025 With s_resetn=0: FSM=IDLE, both FIFOs empty, pointers 0, sdr_req=0, sdr_req_adr=0, sdr_req_len=0, sdr_req_wr_n=1, sdr_wr_en_n=4'hF, sdr_wr_data=0, rd_valid=0, rd_data=0, busy=0, cmd_cnt=0, wr_uflow=0, cmd_ready=1, wd_ready=1.
REQ-026 Reset asserted mid-transfer SHALL return all state to REQ-025 values immediately; no partial beats are retained.

Verification
REQ-027 Init gate: a read command is queued with sdr_init_done=0 -> sdr_req stays 0; after init_done rises, sdr_req=1 within 2 cycles.
REQ-028 Write burst: push 4 words A0..A3, then write cmd adr=0x100 len=3 -> sdr_req held until ack; 4 sdr_wr_next pulses present A0..A3 in order; FSM returns to IDLE and busy=0.
REQ-029 Write gating: write cmd len=3 with only 2 words queued -> no sdr_req; pushing 2 more words -> request issues.
REQ-030 Read burst: read cmd len=1, two sdr_rd_valid beats with data D0, D1 -> rd_valid high for 2 cycles, each 1 cycle after its beat, with D0 then D1.
REQ-031 Full/underflow: 5 commands offered -> cmd_ready=0 after the 4th; a stray sdr_wr_next with an empty write FIFO -> wr_uflow=1 and stays 1.
REQ-032 Reset mid-WXFER after 2 of 4 beats -> all outputs return to REQ-025 values, and a new command after reset runs correctly.
